io_port_sequencer: RTL

IO_PORT_SEQUENCER -- requirements
Module: io_port_sequencer

---
 rtl/io_port_pkg.sv | 32 +++
 rtl/io_port_match.sv | 35 +++
 rtl/io_port_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/io_port_pkg.sv
// Shared types, defaults and small helpers for the I/O port sequencer.
// Default tables place channel 0 at the low byte of each packed vector.
package io_port_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACTIVE = 2'd2,
        HOLD   = 2'd3
    } ioState_e;

    localparam int DEF_NCH    = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_WAIT_W = 4;

    // ch7 .. ch0; ch0 masks off bit 0 so it answers at both 0x00 and 0x01
    localparam logic [DEF_NCH*DEF_ADDR_W-1:0] DEF_PORT_ADDR = {
        8'h80, 8'hFF, 8'h36, 8'h35, 8'h34, 8'h07, 8'h06, 8'h00
    };
    localparam logic [DEF_NCH*DEF_ADDR_W-1:0] DEF_PORT_MASK = {
        8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFE
    };

    function automatic logic singleStrobe(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

    function automatic logic selStrobe(input logic isWrite, input logic rd, input logic wr);
        return isWrite ? wr : rd;
    endfunction

endpackage

// File: rtl/io_port_match.sv
// Masked address compare against every channel, then a priority encode
// so that the lowest matching channel index wins.
module io_port_match import io_port_pkg::*; #(
    parameter int NCH    = DEF_NCH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int IDX_W  = (NCH > 1) ? $clog2(NCH) : 1,
    parameter logic [NCH*ADDR_W-1:0] PORT_ADDR = DEF_PORT_ADDR,
    parameter logic [NCH*ADDR_W-1:0] PORT_MASK = DEF_PORT_MASK
) (
    input  logic [ADDR_W-1:0] address,
    output logic              hit,
    output logic [IDX_W-1:0]  index
);

    logic [NCH-1:0] matchVec_s;

    // Per-channel masked compare
    always_comb begin
        matchVec_s = {NCH{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            matchVec_s[i] = ((address & PORT_MASK[i*ADDR_W +: ADDR_W]) ==
                             (PORT_ADDR[i*ADDR_W +: ADDR_W] & PORT_MASK[i*ADDR_W +: ADDR_W]));
        end
    end

    // Priority encode: walk downward so the lowest index is written last
    always_comb begin
        hit   = |matchVec_s;
        index = {IDX_W{1'b0}};
        for (int i = NCH - 1; i >= 0; i--) begin
            index = matchVec_s[i] ? i[IDX_W-1:0] : index;
        end
    end

endmodule

// File: rtl/io_port_sequencer.sv
// CPU I/O port sequencer: decodes the port address, drives registered
// chip selects, inserts per-channel wait states and commits writes.
module io_port_sequencer import io_port_pkg::*; #(
    parameter int NCH    = DEF_NCH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WAIT_W = DEF_WAIT_W,
    parameter logic [NCH*ADDR_W-1:0] PORT_ADDR = DEF_PORT_ADDR,
    parameter logic [NCH*ADDR_W-1:0] PORT_MASK = DEF_PORT_MASK,
    parameter logic [NCH*WAIT_W-1:0] WAIT_CYC  = {(NCH*WAIT_W){1'b0}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic              ioread,
    input  logic              iowrite,
    output logic [NCH-1:0]    rd_cs,
    output logic [NCH-1:0]    wr_cs,
    output logic [NCH-1:0]    wr_stb,
    output logic              io_ready,
    output logic              unmapped,
    output logic              busy
);

    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};

    ioState_e          state_r;
    logic              isWrite_r;
    logic [IDX_W-1:0]  chan_r;
    logic [WAIT_W-1:0] waitCnt_r;
    logic [NCH-1:0]    rdCs_r, wrCs_r, wrStb_r;
    logic              ioReady_r, unmapped_r, busy_r;

    logic              hit_s, startReq_s, strobe_s;
    logic [IDX_W-1:0]  matchIdx_s;
    logic [WAIT_W-1:0] waitSel_s;

    function automatic logic [NCH-1:0] chanOneHot(input logic [IDX_W-1:0] idx);
        logic [NCH-1:0] vec;
        vec      = {NCH{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

    io_port_match #(
        .NCH       (NCH),
        .ADDR_W    (ADDR_W),
        .IDX_W     (IDX_W),
        .PORT_ADDR (PORT_ADDR),
        .PORT_MASK (PORT_MASK)
    ) uMatch (
        .address (address),
        .hit     (hit_s),
        .index   (matchIdx_s)
    );

    assign startReq_s = singleStrobe(ioread, iowrite);
    assign strobe_s   = selStrobe(isWrite_r, ioread, iowrite);

    // Wait-state count of the channel currently being decoded
    always_comb begin
        waitSel_s = WAIT_ZERO;
        for (int i = 0; i < NCH; i++) begin
            waitSel_s = (matchIdx_s == i[IDX_W-1:0]) ? WAIT_CYC[i*WAIT_W +: WAIT_W] : waitSel_s;
        end
    end

    // Access sequencer; every output is a register updated here
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            isWrite_r  <= 1'b0;
            chan_r     <= {IDX_W{1'b0}};
            waitCnt_r  <= WAIT_ZERO;
            rdCs_r     <= {NCH{1'b0}};
            wrCs_r     <= {NCH{1'b0}};
            wrStb_r    <= {NCH{1'b0}};
            ioReady_r  <= 1'b1;
            unmapped_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            wrStb_r    <= {NCH{1'b0}};
            unmapped_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (startReq_s) begin
                        isWrite_r <= iowrite;
                        chan_r    <= matchIdx_s;
                        busy_r    <= 1'b1;
                        if (hit_s) begin
                            rdCs_r <= iowrite ? {NCH{1'b0}} : chanOneHot(matchIdx_s);
                            wrCs_r <= iowrite ? chanOneHot(matchIdx_s) : {NCH{1'b0}};
                            if (waitSel_s != WAIT_ZERO) begin
                                state_r   <= WAIT;
                                waitCnt_r <= waitSel_s;
                                ioReady_r <= 1'b0;
                            end else begin
                                state_r <= ACTIVE;
                            end
                        end else begin
                            state_r    <= HOLD;
                            unmapped_r <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (!strobe_s) begin
                        // Abort: the CPU gave up before the device was ready
                        state_r   <= IDLE;
                        rdCs_r    <= {NCH{1'b0}};
                        wrCs_r    <= {NCH{1'b0}};
                        waitCnt_r <= WAIT_ZERO;
                        ioReady_r <= 1'b1;
                        busy_r    <= 1'b0;
                    end else if (waitCnt_r == WAIT_ONE) begin
                        state_r   <= ACTIVE;
                        waitCnt_r <= WAIT_ZERO;
                        ioReady_r <= 1'b1;
                    end else begin
                        waitCnt_r <= waitCnt_r - WAIT_ONE;
                    end
                end
                ACTIVE: begin
                    if (!strobe_s) begin
                        state_r <= IDLE;
                        rdCs_r  <= {NCH{1'b0}};
                        wrCs_r  <= {NCH{1'b0}};
                        wrStb_r <= isWrite_r ? chanOneHot(chan_r) : {NCH{1'b0}};
                        busy_r  <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!strobe_s) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    rdCs_r    <= {NCH{1'b0}};
                    wrCs_r    <= {NCH{1'b0}};
                    waitCnt_r <= WAIT_ZERO;
                    ioReady_r <= 1'b1;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign rd_cs    = rdCs_r;
    assign wr_cs    = wrCs_r;
    assign wr_stb   = wrStb_r;
    assign io_ready = ioReady_r;
    assign unmapped = unmapped_r;
    assign busy     = busy_r;

endmodule
